// File: rtl/reg_file_hs.sv
// Handshaked 16x32 register file: two write ports, four read ports, PC aliased at the top address, separate CSPR.
// Optional macro RF_BYPASS_EN selects write-first forwarding; the default build is read-first.
module reg_file_hs #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req,
   output logic              ack,
   input  logic [ADDR_W-1:0] in_address1,
   input  logic [ADDR_W-1:0] in_address2,
   input  logic [ADDR_W-1:0] in_address3,
   input  logic [ADDR_W-1:0] in_address4,
   input  logic              read_enable,
   input  logic [ADDR_W-1:0] write_address,
   input  logic [DATA_W-1:0] write_data,
   input  logic              write_enable,
   input  logic [ADDR_W-1:0] write_address2,
   input  logic [DATA_W-1:0] write_data2,
   input  logic              write_enable2,
   input  logic [DATA_W-1:0] pc_update,
   input  logic              pc_write,
   input  logic [DATA_W-1:0] cspr_update,
   input  logic              cspr_write,
   output logic [DATA_W-1:0] out_data1,
   output logic [DATA_W-1:0] out_data2,
   output logic [DATA_W-1:0] out_data3,
   output logic [DATA_W-1:0] out_data4,
   output logic [DATA_W-1:0] pc,
   output logic [DATA_W-1:0] cspr
);

   localparam int unsigned        NREGS   = 2 ** ADDR_W;
   localparam logic [ADDR_W-1:0]  PC_ADDR = '1;

   typedef enum logic {IDLE, ACKED} state_t;
   state_t state;

   // Only the addresses below PC_ADDR need storage; the top address is the PC itself.
   logic [DATA_W-1:0] regs     [NREGS-1];
   logic [DATA_W-1:0] regs_nxt [NREGS-1];
   logic [DATA_W-1:0] src      [NREGS-1];
   logic [DATA_W-1:0] pc_nxt;
   logic [DATA_W-1:0] src_pc;
   logic [ADDR_W-1:0] rd_addr  [4];
   logic [DATA_W-1:0] rd_val   [4];
   logic              exec;

   assign exec = (state == IDLE) && req;

   assign rd_addr[0] = in_address1;
   assign rd_addr[1] = in_address2;
   assign rd_addr[2] = in_address3;
   assign rd_addr[3] = in_address4;

   always_comb begin
      for (int unsigned i = 0; i < NREGS - 1; i++) begin
         regs_nxt[i] = regs[i];
         if (write_enable && (write_address == ADDR_W'(i)))
            regs_nxt[i] = write_data;
         if (write_enable2 && (write_address2 == ADDR_W'(i)))
            regs_nxt[i] = write_data2;
      end
   end

   always_comb begin
      pc_nxt = pc;
      if (write_enable && (write_address == PC_ADDR))
         pc_nxt = write_data;
      if (write_enable2 && (write_address2 == PC_ADDR))
         pc_nxt = write_data2;
      if (pc_write)
         pc_nxt = pc_update;
   end

   always_comb begin
      for (int unsigned i = 0; i < NREGS - 1; i++) begin
`ifdef RF_BYPASS_EN
         src[i] = regs_nxt[i];
`else
         src[i] = regs[i];
`endif
      end
`ifdef RF_BYPASS_EN
      src_pc = pc_nxt;
`else
      src_pc = pc;
`endif
   end

   always_comb begin
      for (int unsigned n = 0; n < 4; n++) begin
         rd_val[n] = '0;
         if (rd_addr[n] == PC_ADDR)
            rd_val[n] = src_pc;
         else
            rd_val[n] = src[rd_addr[n]];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         ack       <= 1'b0;
         pc        <= '0;
         cspr      <= '0;
         out_data1 <= '0;
         out_data2 <= '0;
         out_data3 <= '0;
         out_data4 <= '0;
         for (int unsigned i = 0; i < NREGS - 1; i++)
            regs[i] <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req) begin
                  for (int unsigned i = 0; i < NREGS - 1; i++)
                     regs[i] <= regs_nxt[i];
                  pc <= pc_nxt;
                  if (cspr_write)
                     cspr <= cspr_update;
                  if (read_enable) begin
                     out_data1 <= rd_val[0];
                     out_data2 <= rd_val[1];
                     out_data3 <= rd_val[2];
                     out_data4 <= rd_val[3];
                  end
                  ack   <= 1'b1;
                  state <= ACKED;
               end
            end
            ACKED: begin
               if (!req) begin
                  ack   <= 1'b0;
                  state <= IDLE;
               end
            end
            default: begin
               ack   <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_reg_file_hs.sv
// Directed self-checking bench for reg_file_hs; expectations follow RF_BYPASS_EN when defined.
module tb_reg_file_hs;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned ADDR_W = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic              req;
   logic              ack;
   logic [ADDR_W-1:0] in_address1, in_address2, in_address3, in_address4;
   logic              read_enable;
   logic [ADDR_W-1:0] write_address, write_address2;
   logic [DATA_W-1:0] write_data, write_data2;
   logic              write_enable, write_enable2;
   logic [DATA_W-1:0] pc_update, cspr_update;
   logic              pc_write, cspr_write;
   logic [DATA_W-1:0] out_data1, out_data2, out_data3, out_data4;
   logic [DATA_W-1:0] pc, cspr;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   reg_file_hs #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst(rst), .req(req), .ack(ack),
      .in_address1(in_address1), .in_address2(in_address2),
      .in_address3(in_address3), .in_address4(in_address4),
      .read_enable(read_enable),
      .write_address(write_address), .write_data(write_data), .write_enable(write_enable),
      .write_address2(write_address2), .write_data2(write_data2), .write_enable2(write_enable2),
      .pc_update(pc_update), .pc_write(pc_write),
      .cspr_update(cspr_update), .cspr_write(cspr_write),
      .out_data1(out_data1), .out_data2(out_data2),
      .out_data3(out_data3), .out_data4(out_data4),
      .pc(pc), .cspr(cspr)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_ctrl();
      write_enable  = 1'b0;
      write_enable2 = 1'b0;
      pc_write      = 1'b0;
      cspr_write    = 1'b0;
      read_enable   = 1'b0;
   endtask

   // One four-phase transaction with the currently driven inputs; checks ack latency both ways.
   task automatic do_txn();
      req = 1'b1;
      step();
      checks++;
      if (ack !== 1'b1) begin
         errors++;
         $display("FAIL ack_rise: got %b expected 1", ack);
      end
      req = 1'b0;
      clear_ctrl();
      step();
      checks++;
      if (ack !== 1'b0) begin
         errors++;
         $display("FAIL ack_fall: got %b expected 0", ack);
      end
   endtask

   task automatic read4(input logic [ADDR_W-1:0] a1, a2, a3, a4);
      in_address1 = a1;
      in_address2 = a2;
      in_address3 = a3;
      in_address4 = a4;
      read_enable = 1'b1;
      do_txn();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      checks++;
      if (ack !== 1'b0 || pc !== '0 || cspr !== '0) begin
         errors++;
         $display("FAIL reset_ctrl: got ack=%b pc=%h cspr=%h expected 0/0/0", ack, pc, cspr);
      end
      checks++;
      if ({out_data1, out_data2, out_data3, out_data4} !== '0) begin
         errors++;
         $display("FAIL reset_out: got %h %h %h %h expected all 0",
                  out_data1, out_data2, out_data3, out_data4);
      end
      for (int g = 0; g < 4; g++) begin
         read4(ADDR_W'(4*g), ADDR_W'(4*g+1), ADDR_W'(4*g+2), ADDR_W'(4*g+3));
         checks++;
         if ({out_data1, out_data2, out_data3, out_data4} !== '0) begin
            errors++;
            $display("FAIL reset_read_g%0d: got %h %h %h %h expected all 0",
                     g, out_data1, out_data2, out_data3, out_data4);
         end
      end
   endtask

   task automatic test_write_path();
      write_enable  = 1'b1;
      write_address = 4'd0;
      write_data    = 32'h0000_0002;
      do_txn();
      write_enable2  = 1'b1;
      write_address2 = 4'd1;
      write_data2    = 32'h0000_0002;
      do_txn();
      read4(4'd0, 4'd1, 4'd4, 4'd4);
      checks++;
      if (out_data1 !== 32'h0000_0002 || out_data2 !== 32'h0000_0002) begin
         errors++;
         $display("FAIL write_path: got %h %h expected 00000002 00000002", out_data1, out_data2);
      end
   endtask

   task automatic test_mult_writeback();
      write_enable  = 1'b1;
      write_address = 4'd2;
      write_data    = 32'h0000_1000;
      req = 1'b1;
      step();
      // Held request with changed data must not cause a second write.
      write_data = 32'h0BAD_0BAD;
      for (int k = 0; k < 3; k++) begin
         step();
         checks++;
         if (ack !== 1'b1) begin
            errors++;
            $display("FAIL hold_ack_%0d: got %b expected 1", k, ack);
         end
      end
      req = 1'b0;
      clear_ctrl();
      step();
      read4(4'd4, 4'd4, 4'd2, 4'd4);
      checks++;
      if (out_data3 !== 32'h0000_1000) begin
         errors++;
         $display("FAIL mult_writeback: got %h expected 00001000", out_data3);
      end
   endtask

   task automatic test_collision();
      write_enable   = 1'b1;
      write_address  = 4'd5;
      write_data     = 32'h1111_1111;
      write_enable2  = 1'b1;
      write_address2 = 4'd5;
      write_data2    = 32'h2222_2222;
      do_txn();
      read4(4'd5, 4'd0, 4'd1, 4'd2);
      checks++;
      if (out_data1 !== 32'h2222_2222) begin
         errors++;
         $display("FAIL collision_r5: got %h expected 22222222", out_data1);
      end
      write_enable  = 1'b1;
      write_address = 4'd15;
      write_data    = 32'hAAAA_0000;
      pc_write      = 1'b1;
      pc_update     = 32'h0000_0040;
      do_txn();
      checks++;
      if (pc !== 32'h0000_0040) begin
         errors++;
         $display("FAIL pc_priority: got %h expected 00000040", pc);
      end
      read4(4'd15, 4'd5, 4'd15, 4'd15);
      checks++;
      if (out_data1 !== 32'h0000_0040 || out_data2 !== 32'h2222_2222) begin
         errors++;
         $display("FAIL pc_alias_read: got %h %h expected 00000040 22222222", out_data1, out_data2);
      end
      write_enable2  = 1'b1;
      write_address2 = 4'd15;
      write_data2    = 32'h0000_0100;
      do_txn();
      checks++;
      if (pc !== 32'h0000_0100) begin
         errors++;
         $display("FAIL pc_via_gpr: got %h expected 00000100", pc);
      end
   endtask

   task automatic test_bypass();
      logic [DATA_W-1:0] exp_same;
`ifdef RF_BYPASS_EN
      exp_same = 32'hDEAD_BEEF;
`else
      exp_same = 32'h0000_0000;
`endif
      write_enable  = 1'b1;
      write_address = 4'd3;
      write_data    = 32'hDEAD_BEEF;
      read4(4'd3, 4'd5, 4'd0, 4'd15);
      checks++;
      if (out_data1 !== exp_same) begin
         errors++;
         $display("FAIL bypass_same_txn: got %h expected %h", out_data1, exp_same);
      end
      read4(4'd3, 4'd5, 4'd0, 4'd15);
      checks++;
      if (out_data1 !== 32'hDEAD_BEEF || out_data4 !== 32'h0000_0100) begin
         errors++;
         $display("FAIL bypass_next_txn: got %h %h expected deadbeef 00000100", out_data1, out_data4);
      end
      in_address1 = 4'd0;
      do_txn();
      checks++;
      if (out_data1 !== 32'hDEAD_BEEF) begin
         errors++;
         $display("FAIL read_hold: got %h expected deadbeef", out_data1);
      end
   endtask

   task automatic test_cspr_reset();
      cspr_write  = 1'b1;
      cspr_update = 32'hF000_0000;
      do_txn();
      checks++;
      if (cspr !== 32'hF000_0000) begin
         errors++;
         $display("FAIL cspr_write: got %h expected f0000000", cspr);
      end
      req = 1'b1;
      step();
      rst = 1'b1;
      step();
      checks++;
      if (ack !== 1'b0 || pc !== '0 || cspr !== '0) begin
         errors++;
         $display("FAIL reset_mid_txn: got ack=%b pc=%h cspr=%h expected 0/0/0", ack, pc, cspr);
      end
      req = 1'b0;
      rst = 1'b0;
      step();
      read4(4'd2, 4'd3, 4'd5, 4'd15);
      checks++;
      if ({out_data1, out_data2, out_data3, out_data4} !== '0) begin
         errors++;
         $display("FAIL reset_cleared: got %h %h %h %h expected all 0",
                  out_data1, out_data2, out_data3, out_data4);
      end
   endtask

   initial begin
      rst = 1'b1;
      req = 1'b0;
      in_address1 = '0;
      in_address2 = '0;
      in_address3 = '0;
      in_address4 = '0;
      write_address  = '0;
      write_address2 = '0;
      write_data  = '0;
      write_data2 = '0;
      pc_update   = '0;
      cspr_update = '0;
      clear_ctrl();
      test_reset();
      test_write_path();
      test_mult_writeback();
      test_collision();
      test_bypass();
      test_cspr_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
